// File: rtl/lcd_display_sequencer_if.sv
// Handshake bundle between the display sequencer and the LCD byte-write engine.
// The sequencer side is the master; the write engine is the slave.
interface lcd_display_sequencer_if;
    logic [7:0] oLCD_DATA;
    logic       oLCD_RS;
    logic       oLCD_START;
    logic       iLCD_DONE;

    modport master (output oLCD_DATA, output oLCD_RS, output oLCD_START, input iLCD_DONE);
    modport slave  (input oLCD_DATA, input oLCD_RS, input oLCD_START, output iLCD_DONE);
endinterface

// File: rtl/lcd_display_sequencer.sv
// Drives a 2x16 character LCD: power-up wait, init commands, then refreshes from a 32-byte buffer.
// Optional macro LCD_SEQ_AUTO_REFRESH_EN: refresh continuously instead of waiting for iUPDATE.
module lcd_display_sequencer #(
    parameter int INIT_WAIT = 1000000,
    parameter int CMD_WAIT  = 2000,
    parameter int CLR_WAIT  = 82000
) (
    input  logic                          iCLK,
    input  logic                          iRST_N,
    input  logic                          iWR_EN,
    input  logic [4:0]                    iWR_ADDR,
    input  logic [7:0]                    iWR_DATA,
    input  logic                          iUPDATE,
    lcd_display_sequencer_if.master       lcd,
    output logic                          oBUSY,
    output logic                          oINIT_DONE
);

    typedef enum logic [2:0] {PWRUP, ISSUE, WAIT_DONE, GAP, IDLE} state_t;

    state_t      state, state_nxt;
    logic [5:0]  idx, idx_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [31:0] gap_len;
    logic [7:0]  char_buf [32];
    logic [7:0]  data_q, item_data;
    logic        rs_q, item_rs;
    logic        start_q, init_done_q, pending, done_prev, set_init;
    logic [4:0]  buf_sel;

    // The clear command needs a much longer settle time than anything else.
    assign gap_len = (!rs_q && data_q == 8'h01) ? 32'(CLR_WAIT) : 32'(CMD_WAIT);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) char_buf[i] <= 8'h20;
        end else if (iWR_EN) begin
            char_buf[iWR_ADDR] <= iWR_DATA;
        end
    end

    always_comb begin
        item_data = 8'h00;
        item_rs   = 1'b0;
        buf_sel   = 5'(idx_nxt - 6'd5);
        if (idx_nxt > 6'd21) buf_sel = 5'(idx_nxt - 6'd6);
        case (idx_nxt)
            6'd0:    item_data = 8'h38;
            6'd1:    item_data = 8'h0C;
            6'd2:    item_data = 8'h01;
            6'd3:    item_data = 8'h06;
            6'd4:    item_data = 8'h80;
            6'd21:   item_data = 8'hC0;
            default: begin
                item_data = char_buf[buf_sel];
                item_rs   = 1'b1;
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + 32'd1;
        set_init  = 1'b0;
        case (state)
            PWRUP: begin
                if (cnt + 32'd1 >= 32'(INIT_WAIT)) begin
                    state_nxt = ISSUE;
                    idx_nxt   = 6'd0;
                    cnt_nxt   = 32'd0;
                end
            end
            ISSUE: begin
                state_nxt = WAIT_DONE;
                cnt_nxt   = 32'd0;
            end
            WAIT_DONE: begin
                cnt_nxt = 32'd0;
                // Only a fresh rising edge counts; a level left high from before is ignored.
                if (lcd.iLCD_DONE && !done_prev) state_nxt = GAP;
            end
            GAP: begin
                if (cnt + 32'd1 >= gap_len) begin
                    cnt_nxt  = 32'd0;
                    set_init = (idx == 6'd3);
                    if (idx == 6'd37) begin
`ifdef LCD_SEQ_AUTO_REFRESH_EN
                        state_nxt = ISSUE;
                        idx_nxt   = 6'd4;
`else
                        state_nxt = IDLE;
`endif
                    end else begin
                        state_nxt = ISSUE;
                        idx_nxt   = idx + 6'd1;
                    end
                end
            end
            IDLE: begin
                cnt_nxt = 32'd0;
                if (iUPDATE || pending) begin
                    state_nxt = ISSUE;
                    idx_nxt   = 6'd4;
                end
            end
            default: begin
                state_nxt = PWRUP;
                idx_nxt   = 6'd0;
                cnt_nxt   = 32'd0;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state       <= PWRUP;
            idx         <= 6'd0;
            cnt         <= 32'd0;
            data_q      <= 8'h00;
            rs_q        <= 1'b0;
            start_q     <= 1'b0;
            init_done_q <= 1'b0;
            pending     <= 1'b0;
            done_prev   <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            done_prev <= lcd.iLCD_DONE;
            start_q   <= (state_nxt == ISSUE);
            // Item byte is captured on entry to ISSUE and held through its GAP.
            if (state_nxt == ISSUE) begin
                data_q <= item_data;
                rs_q   <= item_rs;
            end
            if (set_init) init_done_q <= 1'b1;
            if (state == IDLE) pending <= 1'b0;
            else if (iUPDATE) pending <= 1'b1;
        end
    end

    assign lcd.oLCD_DATA  = data_q;
    assign lcd.oLCD_RS    = rs_q;
    assign lcd.oLCD_START = start_q;
    assign oBUSY          = (state != IDLE);
    assign oINIT_DONE     = init_done_q;

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// Bench for lcd_display_sequencer: engine model, item monitor, and a list-level reference model.
// Adapts to builds with LCD_SEQ_AUTO_REFRESH_EN defined.
module tb_lcd_display_sequencer;

    localparam int INIT_WAIT = 10;
    localparam int CMD_WAIT  = 4;
    localparam int CLR_WAIT  = 8;
`ifdef LCD_SEQ_AUTO_REFRESH_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = 5'd0;
    logic [7:0] wr_data = 8'd0;
    logic       update = 1'b0;
    logic       busy, init_done;

    lcd_display_sequencer_if lcd_bus ();

    lcd_display_sequencer #(
        .INIT_WAIT(INIT_WAIT),
        .CMD_WAIT (CMD_WAIT),
        .CLR_WAIT (CLR_WAIT)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iWR_EN    (wr_en),
        .iWR_ADDR  (wr_addr),
        .iWR_DATA  (wr_data),
        .iUPDATE   (update),
        .lcd       (lcd_bus),
        .oBUSY     (busy),
        .oINIT_DONE(init_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       rs;
        logic       init_done;
    } item_t;

    typedef struct {
        bit         do_wr;
        logic [4:0] addr;
        logic [7:0] wdata;
        int         pos;
        logic       rs_exp;
        logic [7:0] data_exp;
    } vec_t;

    item_t      seen[$];
    logic [8:0] expect_q[$];
    logic [7:0] model_buf [32];
    vec_t       vecs [7];

    int checks = 0, errors = 0;
    int cyc = 0, last_rise = 0, release_cyc = 0;
    int list_pos = 0, list_len = 38;
    int engine_lat = 0, engine_hold = 0;
    bit first_after_reset = 1'b1, chained = 1'b0, prev_was_clr = 1'b0;
    bit watch_busy = 1'b0, busy_fell = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Engine: drops done on a start, raises it after a latency (optionally after holding it high first).
    initial begin
        lcd_bus.iLCD_DONE = 1'b1;
        forever begin
            @(negedge clk);
            if (lcd_bus.oLCD_START === 1'b1) begin
                int lat;
                lat = (engine_lat > 0) ? engine_lat : int'($urandom_range(1, 5));
                repeat (engine_hold) @(negedge clk);
                lcd_bus.iLCD_DONE = 1'b0;
                repeat (lat) @(negedge clk);
                lcd_bus.iLCD_DONE = 1'b1;
                last_rise = cyc;
            end
        end
    end

    // Monitor: logs each item and checks start spacing against the done rise and required gap.
    always @(negedge clk) begin
        if (watch_busy && busy !== 1'b1) busy_fell = 1'b1;
        if (lcd_bus.oLCD_START === 1'b1) begin
            seen.push_back({lcd_bus.oLCD_DATA, lcd_bus.oLCD_RS, init_done});
            if (first_after_reset) begin
                check_output("pwrup_delay", cyc - release_cyc, INIT_WAIT);
                first_after_reset = 1'b0;
            end else if (chained) begin
                check_output("gap_timing", cyc - last_rise, prev_was_clr ? CLR_WAIT + 1 : CMD_WAIT + 1);
            end
            prev_was_clr = (lcd_bus.oLCD_DATA == 8'h01 && lcd_bus.oLCD_RS == 1'b0);
            list_pos++;
            if (list_pos == list_len) begin
                list_pos = 0;
                list_len = 34;
                chained  = AUTO;
            end else begin
                chained = 1'b1;
            end
        end
    end

    task automatic add_refresh();
        expect_q.push_back({1'b0, 8'h80});
        for (int i = 0; i < 16; i++) expect_q.push_back({1'b1, model_buf[i]});
        expect_q.push_back({1'b0, 8'hC0});
        for (int i = 16; i < 32; i++) expect_q.push_back({1'b1, model_buf[i]});
    endtask

    task automatic add_init();
        expect_q.push_back({1'b0, 8'h38});
        expect_q.push_back({1'b0, 8'h0C});
        expect_q.push_back({1'b0, 8'h01});
        expect_q.push_back({1'b0, 8'h06});
        add_refresh();
    endtask

    task automatic compare_list(input string tag);
        check_output({tag, "_count"}, seen.size(), expect_q.size());
        for (int i = 0; i < expect_q.size() && i < seen.size(); i++)
            check_output($sformatf("%s_item%0d", tag, i), {seen[i].rs, seen[i].data}, expect_q[i]);
    endtask

    task automatic wait_items(input int n, input string tag);
        int c = 0;
        while (seen.size() < n && c < 3000) begin
            @(negedge clk); #1;
            c++;
        end
        check_output({tag, "_arrived"}, seen.size() >= n, 1);
    endtask

    task automatic wait_idle(input string tag);
        int c = 0;
        while (busy !== 1'b0 && c < 3000) begin
            @(negedge clk); #1;
            c++;
        end
        check_output({tag, "_idle"}, busy, 0);
    endtask

    task automatic apply_stimulus(input logic [4:0] addr, input logic [7:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = addr; wr_data = data;
        @(negedge clk);
        wr_en = 1'b0;
        model_buf[addr] = data;
    endtask

    task automatic pulse_update();
        @(negedge clk); update = 1'b1;
        @(negedge clk); update = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_data"},  lcd_bus.oLCD_DATA, 8'h00);
        check_output({tag, "_rs"},    lcd_bus.oLCD_RS, 0);
        check_output({tag, "_start"}, lcd_bus.oLCD_START, 0);
        check_output({tag, "_busy"},  busy, 1);
        check_output({tag, "_initd"}, init_done, 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        release_cyc = cyc;
        first_after_reset = 1'b1;
        chained = 1'b0;
        list_pos = 0;
        list_len = 38;
        seen.delete();
        expect_q.delete();
        for (int i = 0; i < 32; i++) model_buf[i] = 8'h20;
    endtask

    initial begin
        vecs[0] = '{1'b1, 5'd0,  8'h41, 1,  1'b1, 8'h41};
        vecs[1] = '{1'b1, 5'd31, 8'h5A, 33, 1'b1, 8'h5A};
        vecs[2] = '{1'b1, 5'd15, 8'h7E, 16, 1'b1, 8'h7E};
        vecs[3] = '{1'b1, 5'd16, 8'h30, 18, 1'b1, 8'h30};
        vecs[4] = '{1'b1, 5'd2,  8'h01, 3,  1'b1, 8'h01};
        vecs[5] = '{1'b0, 5'd0,  8'h00, 0,  1'b0, 8'h80};
        vecs[6] = '{1'b0, 5'd0,  8'h00, 17, 1'b0, 8'hC0};

        repeat (2) @(negedge clk);
        #1;
        check_reset_values("reset");
        release_reset();
        add_init();

        if (AUTO) begin
            // Continuous refresh: init list then three full refreshes with busy never dropping.
            for (int r = 0; r < 3; r++) add_refresh();
            watch_busy = 1'b1;
            pulse_update();
            wait_items(140, "auto");
            watch_busy = 1'b0;
            compare_list("auto");
            check_output("auto_busy_fell", busy_fell, 0);
            check_output("auto_initd", init_done, 1);
        end else begin
            wait_items(38, "init");
            wait_idle("init");
            compare_list("init");
            check_output("initd_item3", seen[3].init_done, 0);
            check_output("initd_item4", seen[4].init_done, 1);
            check_output("initd_final", init_done, 1);
            repeat (20) @(negedge clk);
            check_output("init_quiet", seen.size(), 38);

            // Table vectors: writes then one refresh, checking chosen item positions.
            for (int v = 0; v < 7; v++)
                if (vecs[v].do_wr) apply_stimulus(vecs[v].addr, vecs[v].wdata);
            seen.delete(); expect_q.delete();
            add_refresh();
            pulse_update();
            wait_items(34, "vec");
            wait_idle("vec");
            for (int v = 0; v < 7; v++)
                check_output($sformatf("vec%0d", v), {seen[vecs[v].pos].rs, seen[vecs[v].pos].data},
                             {vecs[v].rs_exp, vecs[v].data_exp});
            compare_list("vecfull");

            for (int r = 0; r < 3; r++) begin
                int nw;
                nw = int'($urandom_range(2, 6));
                for (int w = 0; w < nw; w++)
                    apply_stimulus(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
                seen.delete(); expect_q.delete();
                add_refresh();
                repeat ($urandom_range(0, 7)) @(negedge clk);
                pulse_update();
                wait_items(34, $sformatf("rand%0d", r));
                wait_idle($sformatf("rand%0d", r));
                compare_list($sformatf("rand%0d", r));
            end

            // Two update pulses mid-refresh plus a write to an entry in its own ISSUE cycle.
            begin
                logic [7:0] nv;
                int c;
                nv = model_buf[0] ^ 8'hFF;
                seen.delete(); expect_q.delete();
                add_refresh();
                pulse_update();
                c = 0;
                while (seen.size() < 2 && c < 500) begin
                    @(negedge clk); #1;
                    c++;
                end
                check_output("dbl_item5_seen", seen.size(), 2);
                wr_en = 1'b1; wr_addr = 5'd0; wr_data = nv;
                @(negedge clk);
                wr_en = 1'b0;
                model_buf[0] = nv;
                add_refresh();
                pulse_update();
                repeat (30) @(negedge clk);
                pulse_update();
                wait_items(68, "dbl");
                wait_idle("dbl");
                compare_list("dbl");
                repeat (40) @(negedge clk);
                check_output("dbl_quiet", seen.size(), 68);
            end

            // Engine holds done high after the start before completing.
            engine_hold = 3;
            seen.delete(); expect_q.delete();
            add_refresh();
            pulse_update();
            wait_items(34, "hold");
            wait_idle("hold");
            compare_list("hold");
            engine_hold = 0;

            // Reset while item 10 waits for done, then the whole bring-up again.
            apply_stimulus(5'd5, 8'h55);
            engine_lat = 6;
            seen.delete();
            pulse_update();
            wait_items(7, "rst_pre");
            check_output("rst_item10", {seen[6].rs, seen[6].data}, {1'b1, 8'h55});
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            check_reset_values("midreset");
            repeat (3) @(negedge clk);
            release_reset();
            engine_lat = 0;
            add_init();
            wait_items(38, "rst");
            wait_idle("rst");
            compare_list("rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
